// File: rtl/rf68000_node_nic.sv
// Ring NIC for one rf68000 node: takes requests for this node off the ring and runs them on
// the nic_* Wishbone port, then injects the response. Optional timeout: RF68000_NIC_TIMEOUT_EN.
module rf68000_node_nic #(
    parameter logic [7:0] TMO = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  id,
    input  logic [79:0] rx_i,
    output logic [79:0] tx_o,
    output logic        nic_cyc,
    output logic        nic_stb,
    output logic        nic_we,
    output logic [3:0]  nic_sel,
    output logic [31:0] nic_adr,
    output logic [31:0] nic_dato,
    input  logic        nic_ack,
    input  logic [31:0] nic_dati,
    output logic        rsp_v,
    output logic [79:0] rsp_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_SEND} state_t;

    localparam logic [2:0] T_NOP   = 3'd0;
    localparam logic [2:0] T_READ  = 3'd1;
    localparam logic [2:0] T_WRITE = 3'd2;
    localparam logic [2:0] T_RDACK = 3'd3;
    localparam logic [2:0] T_WRACK = 3'd4;
    localparam logic [2:0] T_ERR   = 3'd5;

    state_t      state_q, state_d;
    logic [79:0] tx_q, tx_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dato_q, dato_d;
    logic [3:0]  sid_q, sid_d;
    logic [79:0] resp_q, resp_d;
    logic        rsp_v_q, rsp_v_d;
    logic [79:0] rsp_o_q, rsp_o_d;

    logic [2:0]  rx_type;
    logic        rx_vld, rx_mine, rx_req, rx_rsp, accept, slot_free, tmo_hit;

    assign rx_type   = rx_i[78:76];
    assign rx_vld    = rx_i[79] && (rx_type != T_NOP);
    assign rx_mine   = rx_vld && (rx_i[75:72] == id);
    assign rx_req    = rx_mine && ((rx_type == T_READ) || (rx_type == T_WRITE));
    assign rx_rsp    = rx_mine && ((rx_type == T_RDACK) || (rx_type == T_WRACK) || (rx_type == T_ERR));
    assign accept    = rx_req && (state_q == ST_IDLE);
    // A local response leaves its slot empty, so our response may reuse it.
    assign slot_free = !rx_vld || rx_rsp;

`ifdef RF68000_NIC_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign tmo_hit = (state_q == ST_BUS) && !nic_ack && (cnt_q == TMO);

    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = 8'd0;
        else if ((state_q == ST_BUS) && !nic_ack && !tmo_hit)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end
`else
    logic [7:0] tmo_unused;
    assign tmo_unused = TMO;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)             state_d = ST_BUS;
            ST_BUS:  if (nic_ack || tmo_hit) state_d = ST_SEND;
            ST_SEND: if (slot_free)          state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d    = '0;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dato_d  = dato_q;
        sid_d   = sid_q;
        resp_d  = resp_q;
        rsp_v_d = rx_rsp;
        rsp_o_d = rx_rsp ? rx_i : '0;

        // Foreign traffic and requests we are too busy to serve go round again.
        if (rx_vld && !rx_mine)
            tx_d = rx_i;
        else if (rx_req && !accept)
            tx_d = rx_i;

        if ((state_q == ST_SEND) && slot_free)
            tx_d = resp_q;

        if (accept) begin
            cyc_d  = 1'b1;
            we_d   = (rx_type == T_WRITE);
            sel_d  = rx_i[67:64];
            adr_d  = rx_i[63:32];
            dato_d = rx_i[31:0];
            sid_d  = rx_i[71:68];
        end

        if (state_q == ST_BUS) begin
            if (nic_ack) begin
                cyc_d  = 1'b0;
                resp_d = {1'b1, (we_q ? T_WRACK : T_RDACK), sid_q, id, sel_q, adr_q,
                          (we_q ? dato_q : nic_dati)};
            end else if (tmo_hit) begin
                cyc_d  = 1'b0;
                resp_d = {1'b1, T_ERR, sid_q, id, sel_q, adr_q, 32'hFFFF_FFFF};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_q    <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dato_q  <= '0;
            sid_q   <= '0;
            resp_q  <= '0;
            rsp_v_q <= 1'b0;
            rsp_o_q <= '0;
        end else begin
            tx_q    <= tx_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dato_q  <= dato_d;
            sid_q   <= sid_d;
            resp_q  <= resp_d;
            rsp_v_q <= rsp_v_d;
            rsp_o_q <= rsp_o_d;
        end
    end

    assign tx_o     = tx_q;
    assign nic_cyc  = cyc_q;
    assign nic_stb  = cyc_q;
    assign nic_we   = we_q;
    assign nic_sel  = sel_q;
    assign nic_adr  = adr_q;
    assign nic_dato = dato_q;
    assign rsp_v    = rsp_v_q;
    assign rsp_o    = rsp_o_q;

endmodule

// File: tb/tb_rf68000_node_nic.sv
// Randomized bench for rf68000_node_nic against a transaction-level ring/bus model.
module tb_rf68000_node_nic;

    localparam logic [3:0] ID = 4'd1;
`ifdef RF68000_NIC_TIMEOUT_EN
    localparam logic [7:0] TMO_T = 8'd8;
`else
    localparam logic [7:0] TMO_T = 8'd255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  id = ID;
    logic [79:0] rx_i = '0;
    logic [79:0] tx_o;
    logic        nic_cyc, nic_stb, nic_we;
    logic [3:0]  nic_sel;
    logic [31:0] nic_adr, nic_dato;
    logic        nic_ack = 1'b0;
    logic [31:0] nic_dati = '0;
    logic        rsp_v;
    logic [79:0] rsp_o;

    rf68000_node_nic #(.TMO(TMO_T)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id(id), .rx_i(rx_i), .tx_o(tx_o),
        .nic_cyc(nic_cyc), .nic_stb(nic_stb), .nic_we(nic_we), .nic_sel(nic_sel),
        .nic_adr(nic_adr), .nic_dato(nic_dato), .nic_ack(nic_ack), .nic_dati(nic_dati),
        .rsp_v(rsp_v), .rsp_o(rsp_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: an outstanding bus transaction plus a queue of responses waiting for a free slot.
    logic        m_cyc, m_we, m_rspv;
    logic [3:0]  m_sel, m_sid;
    logic [31:0] m_adr, m_dato;
    logic [79:0] m_tx, m_rspo;
    logic [79:0] pend[$];
    int          m_wait;

    function automatic logic [79:0] pkt(input logic [2:0] t, input logic [3:0] d, input logic [3:0] s,
                                        input logic [3:0] sl, input logic [31:0] a, input logic [31:0] dt);
        return {1'b1, t, d, s, sl, a, dt};
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_we = 0; m_rspv = 0; m_sel = 0; m_sid = 0;
        m_adr = 0; m_dato = 0; m_tx = 0; m_rspo = 0; m_wait = 0;
        pend.delete();
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ":tx"}, tx_o, m_tx);
        check({ctx, ":cyc"}, 80'(nic_cyc), 80'(m_cyc));
        check({ctx, ":stb"}, 80'(nic_stb), 80'(m_cyc));
        check({ctx, ":we"}, 80'(nic_we), 80'(m_we));
        check({ctx, ":sel"}, 80'(nic_sel), 80'(m_sel));
        check({ctx, ":adr"}, 80'(nic_adr), 80'(m_adr));
        check({ctx, ":dato"}, 80'(nic_dato), 80'(m_dato));
        check({ctx, ":rspv"}, 80'(rsp_v), 80'(m_rspv));
        if (m_rspv) check({ctx, ":rspo"}, rsp_o, m_rspo);
    endtask

    task automatic step(input string ctx, input logic [79:0] rx, input logic ack, input logic [31:0] dati);
        logic [2:0] typ;
        logic       v, mine, idle, local_rsp;
        @(negedge clk_i);
        rx_i = rx; nic_ack = ack; nic_dati = dati;
        @(posedge clk_i);
        #1;
        typ       = rx[78:76];
        v         = rx[79] && (typ != 3'd0);
        mine      = v && (rx[75:72] == ID);
        local_rsp = mine && (typ >= 3'd3) && (typ <= 3'd5);
        idle      = !m_cyc && (pend.size() == 0);
        m_tx = '0; m_rspv = 0; m_rspo = '0;
        if (v && !mine) m_tx = rx;
        if (mine && (typ == 3'd1 || typ == 3'd2) && !idle) m_tx = rx;
        if (local_rsp) begin m_rspv = 1; m_rspo = rx; end
        if (pend.size() > 0 && (!v || local_rsp)) m_tx = pend.pop_front();
        if (m_cyc) begin
            if (ack) begin
                pend.push_back(pkt(m_we ? 3'd4 : 3'd3, m_sid, ID, m_sel, m_adr, m_we ? m_dato : dati));
                m_cyc = 0;
            end
`ifdef RF68000_NIC_TIMEOUT_EN
            else if (m_wait == int'(TMO_T)) begin
                pend.push_back(pkt(3'd5, m_sid, ID, m_sel, m_adr, 32'hFFFF_FFFF));
                m_cyc = 0;
            end else m_wait++;
`endif
        end
        if (mine && (typ == 3'd1 || typ == 3'd2) && idle) begin
            m_cyc = 1; m_we = (typ == 3'd2); m_sel = rx[67:64];
            m_adr = rx[63:32]; m_dato = rx[31:0]; m_sid = rx[71:68]; m_wait = 0;
        end
        compare_all(ctx);
        $display("%s rx=%h ack=%0d tx=%h cyc=%0d rsp_v=%0d", ctx, rx, ack, tx_o, nic_cyc, rsp_v);
    endtask

    function automatic logic [79:0] rand_pkt();
        int          r;
        logic [3:0]  d;
        logic [2:0]  t;
        logic [79:0] p;
        r = $urandom_range(0, 9);
        p = {$urandom(), $urandom(), $urandom()};
        case (r)
            0:       p[79] = 1'b0;
            1, 2:    p = '0;
            3, 4: begin
                d = 4'($urandom_range(0, 14));
                if (d >= ID) d = d + 4'd1;
                t = 3'($urandom_range(1, 5));
                p[79] = 1'b1; p[78:76] = t; p[75:72] = d;
            end
            5, 6: begin
                t = 3'($urandom_range(1, 2));
                p[79] = 1'b1; p[78:76] = t; p[75:72] = ID;
            end
            7, 8: begin
                t = 3'($urandom_range(3, 5));
                p[79] = 1'b1; p[78:76] = t; p[75:72] = ID;
            end
            default: begin
                t = 3'($urandom_range(6, 7));
                p[79] = 1'b1; p[78:76] = t; p[75:72] = ID;
            end
        endcase
        return p;
    endfunction

    logic [79:0] foreign_p;

    initial begin
        model_reset();
        foreign_p = pkt(3'd1, 4'd3, 4'd2, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);

        // Reset held with live traffic on the ring.
        rx_i = foreign_p;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst:tx", tx_o, 80'd0);
        check("rst:cyc", 80'(nic_cyc), 80'd0);
        check("rst:rspv", 80'(rsp_v), 80'd0);
        check("rst:rspo", rsp_o, 80'd0);
        check("rst:bus", {8'd0, nic_stb, nic_we, nic_sel, nic_adr, nic_dato}, 80'd0);
        @(negedge clk_i);
        rst_i = 1'b0; rx_i = '0;

        step("fwd", foreign_p, 0, 0);
        step("fwd_gap", '0, 0, 0);

        // READ with ack three clocks into the bus cycle.
        step("rd_req", pkt(3'd1, ID, 4'd2, 4'hF, 32'hFF10_0010, 32'd0), 0, 0);
        step("rd_wait", '0, 0, 0);
        step("rd_wait", '0, 0, 0);
        step("rd_ack", '0, 1, 32'h1234_5678);
        step("rd_resp", '0, 0, 0);

        step("wr_req", pkt(3'd2, ID, 4'd2, 4'b0011, 32'h0000_0040, 32'hA5A5_A5A5), 0, 0);
        step("wr_ack", '0, 1, 32'h0BAD_0BAD);
        step("wr_resp", '0, 0, 0);

        // Busy recirculation, then injection held off by foreign traffic.
        step("busy_req", pkt(3'd1, ID, 4'd2, 4'h1, 32'h10, 32'd0), 0, 0);
        step("busy_2nd", pkt(3'd1, ID, 4'd3, 4'h2, 32'h20, 32'd0), 0, 0);
        step("busy_ack", '0, 1, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) step("busy_hold", foreign_p, 0, 0);
        step("busy_inj", '0, 0, 0);

        // Local response coinciding with a pending injection.
        step("loc_req", pkt(3'd1, ID, 4'd4, 4'hF, 32'h30, 32'd0), 0, 0);
        step("loc_ack", '0, 1, 32'h5555_AAAA);
        step("loc_both", pkt(3'd3, ID, 4'd6, 4'hF, 32'h44, 32'h7777_8888), 0, 0);
        step("loc_only", pkt(3'd4, ID, 4'd7, 4'h3, 32'h48, 32'h0), 0, 0);

`ifdef RF68000_NIC_TIMEOUT_EN
        step("tmo_req", pkt(3'd1, ID, 4'd2, 4'h5, 32'h50, 32'd0), 0, 0);
        for (int i = 0; i < 12; i++) step("tmo_wait", '0, 0, 0);
        step("tmo2_req", pkt(3'd1, ID, 4'd2, 4'h6, 32'h60, 32'd0), 0, 0);
        for (int i = 0; i < 8; i++) step("tmo2_wait", '0, 0, 0);
        step("tmo2_ack", '0, 1, 32'h600D_600D);
        step("tmo2_resp", '0, 0, 0);
`endif

        // Asynchronous reset in the middle of a bus cycle.
        step("mid_req", pkt(3'd1, ID, 4'd2, 4'h1, 32'h70, 32'd0), 0, 0);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_rst:cyc", 80'(nic_cyc), 80'd0);
        check("mid_rst:tx", tx_o, 80'd0);
        @(negedge clk_i);
        rx_i = '0; nic_ack = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        step("post_rst", '0, 0, 0);

        for (int i = 0; i < 3000; i++)
            step("rnd", rand_pkt(), m_cyc && ($urandom_range(0, 2) == 0), $urandom());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
